fracbnn_axil_slave: RTL and testbench
=====================================

FRACBNN_AXIL_SLAVE -- requirements
Module: fracbnn_axil_slave

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the AXI4-Lite data width; only 32 is supported.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, the byte address width covering four 32-bit registers.
REQ-003 The block SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port ARESET, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have the AW channel ports S_AXI_AWADDR in [ADDR_W], S_AXI_AWPROT in [3] (ignored), S_AXI_AWVALID in [1] and S_AXI_AWREADY out [1].
REQ-006 The block SHALL have the W channel ports S_AXI_WDATA in [32], S_AXI_WSTRB in [4], S_AXI_WVALID in [1] and S_AXI_WREADY out [1].
REQ-007 The block SHALL have the B channel ports S_AXI_BRESP out [2], S_AXI_BVALID out [1] and S_AXI_BREADY in [1].
REQ-008 The block SHALL have the AR channel ports S_AXI_ARADDR in [ADDR_W], S_AXI_ARPROT in [3] (ignored), S_AXI_ARVALID in [1] and S_AXI_ARREADY out [1].
REQ-009 The block SHALL have the R channel ports S_AXI_RDATA out [32], S_AXI_RRESP out [2], S_AXI_RVALID out [1] and S_AXI_RREADY in [1].
REQ-010 The block SHALL have ports reg0_o..reg3_o, out, 32 bits each: current register contents, driven to the accelerator.
REQ-011 The block SHALL have port wr_pulse_o, out, 4 bits: one-hot, high for one cycle in the cycle a register is updated.

Function
REQ-012 The AW and W channels SHALL be accepted independently: AWREADY=1 iff no address is latched and BVALID=0; WREADY=1 iff no data is latched and BVALID=0.
REQ-013 Once both the address and the data are latched (same or different cycles), the next edge SHALL update reg[AWADDR[3:2]], set BVALID=1 and clear both latches.
REQ-014 The write SHALL merge per byte: byte k takes WDATA byte k when WSTRB[k]=1; otherwise byte k keeps its old value.
REQ-015 wr_pulse_o SHALL assert in the same cycle that BVALID first rises, for exactly one cycle.
REQ-016 BVALID SHALL hold until BREADY=1; BRESP SHALL be 2'b00 (OKAY).
REQ-017 ARREADY SHALL be high iff RVALID=0.
REQ-018 On an AR handshake, the next edge SHALL register RDATA=reg[ARADDR[3:2]] and set RVALID=1; the latency is 1 cycle.
REQ-019 RVALID and RDATA SHALL hold stable until RREADY=1; RRESP SHALL be 2'b00.
REQ-020 Address bits [1:0] SHALL be ignored, so unaligned addresses alias to the containing word.
REQ-021 The read and write paths SHALL be fully concurrent.
REQ-022 A read sampled in the same cycle as a write update to the same register SHALL return the pre-write value.
REQ-023 At most one write and one read SHALL be outstanding; back-pressure on B or R SHALL stall only its own path.
REQ-024 Write-side states SHALL be IDLE, HAVE_AW, HAVE_W, HAVE_BOTH and RESP, with the transitions implied by REQ-012 to REQ-016.
REQ-025 RESP SHALL return to IDLE on BREADY.

Reset
REQ-026 While ARESET=1 at an edge, all registers, latches, reg*_o, wr_pulse_o, BVALID, RVALID, RDATA, AWREADY, WREADY and ARREADY SHALL become 0.
REQ-027 In the first cycle after reset, AWREADY, WREADY and ARREADY SHALL be 1.
REQ-028 A reset asserted mid-transaction SHALL abort it with no register update and no response issued.

Structure
REQ-029 Package fracbnn_axil_pkg SHALL hold RESP_OKAY, the REG_CTRL..REG_3 index constants, the write-state enum and a byte-strobe merge function.
REQ-030 No sub-module SHALL be used; the write and read paths are two processes in one module.

Verification
REQ-031 The bench SHALL cover: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> 0x1..0x4, OKAY responses, wr_pulse_o 0001,0010,0100,1000.
REQ-032 The bench SHALL cover: WVALID (0xDEADBEEF) 3 cycles before AWVALID (0x8) -> a single update, reg2_o=0xDEADBEEF one cycle after the AW handshake.
REQ-033 The bench SHALL cover: reg1=0x00000002, then write 0xAABBCCDD with WSTRB=0010 -> reg1_o=0x0000CC02.
REQ-034 The bench SHALL cover: BREADY held 0 for 5 cycles -> BVALID stays 1, AWREADY and WREADY stay 0, and a second write is not accepted until the B handshake.
REQ-035 The bench SHALL cover: a read of 0x4 in the same cycle that a write of 0x55 to 0x4 updates -> RDATA is the old value, and a following read returns 0x55.
REQ-036 The bench SHALL cover: ARESET pulsed while RVALID=1 and RREADY=0 -> RVALID=0 the next cycle, all reg*_o=0, ARREADY=1.

Source files
------------

// File: rtl/fracbnn_axil_pkg.sv
// rtl/fracbnn_axil_pkg.sv - shared constants, write-state encoding and byte-merge helper for the AXI4-Lite register slave
package fracbnn_axil_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_1    = 2'd1;
  localparam logic [1:0] REG_2    = 2'd2;
  localparam logic [1:0] REG_3    = 2'd3;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_HAVE_BOTH,
    WR_RESP
  } wr_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] result;
    result = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) result[8*k +: 8] = new_val[8*k +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/fracbnn_axil_slave.sv
// rtl/fracbnn_axil_slave.sv - four-register AXI4-Lite slave feeding the accelerator
// Write and read paths run concurrently; each allows one outstanding transaction.
module fracbnn_axil_slave
  import fracbnn_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      wr_pulse_o
);

  wr_state_e   wr_state_q, wr_state_d;
  logic [1:0]  wr_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] regs_q [4];
  logic [3:0]  wr_pulse_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic aw_ready, w_ready, ar_ready;
  logic aw_hs, w_hs, ar_hs;

  // Readies are gated by reset so they drop while reset is held and rise as soon as it releases.
  assign aw_ready = !ARESET && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_W);
  assign w_ready  = !ARESET && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_AW);
  assign ar_ready = !ARESET && !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && aw_ready;
  assign w_hs  = S_AXI_WVALID  && w_ready;
  assign ar_hs = S_AXI_ARVALID && ar_ready;

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = WR_HAVE_BOTH;
        else if (aw_hs)    wr_state_d = WR_HAVE_AW;
        else if (w_hs)     wr_state_d = WR_HAVE_W;
      end
      WR_HAVE_AW:   if (w_hs)  wr_state_d = WR_HAVE_BOTH;
      WR_HAVE_W:    if (aw_hs) wr_state_d = WR_HAVE_BOTH;
      WR_HAVE_BOTH: wr_state_d = WR_RESP;
      WR_RESP:      if (S_AXI_BREADY) wr_state_d = WR_IDLE;
      default:      wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) wr_state_q <= WR_IDLE;
    else        wr_state_q <= wr_state_d;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (aw_hs) wr_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_state_q == WR_HAVE_BOTH) begin
        regs_q[wr_idx_q] <= strb_merge(regs_q[wr_idx_q], wdata_q, wstrb_q);
        wr_pulse_q       <= 4'b0001 << wr_idx_q;
      end
    end
  end

  // Reads sample regs_q before any same-edge write lands, so they see the pre-write value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs_q[S_AXI_ARADDR[3:2]];
    end else if (S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign reg0_o     = regs_q[REG_CTRL];
  assign reg1_o     = regs_q[REG_1];
  assign reg2_o     = regs_q[REG_2];
  assign reg3_o     = regs_q[REG_3];
  assign wr_pulse_o = wr_pulse_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_fracbnn_axil_slave.sv
// tb/tb_fracbnn_axil_slave.sv - scoreboard bench for the AXI4-Lite register slave
module tb_fracbnn_axil_slave;

  logic        ACLK, ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
  logic [3:0]  wr_pulse_o;

  fracbnn_axil_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
    .wr_pulse_o(wr_pulse_o)
  );

  typedef struct {
    logic [3:0]  pulse;
    int          idx;
    logic [31:0] val;
  } pulse_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model [4];
  pulse_t      pq[$];
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  int          b_issued = 0, b_seen = 0, r_issued = 0, r_seen = 0;
  int          last_pulse_cyc = -1;
  bit          bp_en = 0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] get_reg(input int idx);
    case (idx)
      0:       return reg0_o;
      1:       return reg1_o;
      2:       return reg2_o;
      default: return reg3_o;
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response or an update pulse.
  initial begin
    logic [3:0] prev_pulse;
    logic       prev_bvalid;
    pulse_t     p;
    prev_pulse  = '0;
    prev_bvalid = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          if (bq.size() == 0) chk("unexpected_b", {31'd0, S_AXI_BVALID}, 32'd0);
          else chk("bresp", {30'd0, S_AXI_BRESP}, {30'd0, bq.pop_front()});
          b_seen++;
        end
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          if (rq.size() == 0) chk("unexpected_r", {31'd0, S_AXI_RVALID}, 32'd0);
          else chk("rdata", S_AXI_RDATA, rq.pop_front());
          chk("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
          r_seen++;
        end
        if (wr_pulse_o != 4'd0) begin
          last_pulse_cyc = cyc;
          chk("pulse_one_cycle", {28'd0, prev_pulse}, 32'd0);
          chk("bvalid_rises_with_pulse", {30'd0, S_AXI_BVALID, prev_bvalid}, 32'd2);
          if (pq.size() == 0) chk("unexpected_pulse", {28'd0, wr_pulse_o}, 32'd0);
          else begin
            p = pq.pop_front();
            chk("wr_pulse", {28'd0, wr_pulse_o}, {28'd0, p.pulse});
            chk("reg_after_write", get_reg(p.idx), p.val);
          end
        end
      end
      prev_pulse  = ARESET ? 4'd0 : wr_pulse_o;
      prev_bvalid = ARESET ? 1'b0 : S_AXI_BVALID;
    end
  end

  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      if (bp_en) begin
        S_AXI_BREADY = ($urandom_range(0, 9) < 7);
        S_AXI_RREADY = ($urandom_range(0, 9) < 7);
      end
    end
  end

  task automatic wait_b();
    int n = 0;
    while (b_seen < b_issued && n < 200) begin
      @(posedge ACLK); #1; n++;
    end
    if (b_seen < b_issued) fail_timeout("b_response");
  endtask

  task automatic wait_r();
    int n = 0;
    while (r_seen < r_issued && n < 200) begin
      @(posedge ACLK); #1; n++;
    end
    if (r_seen < r_issued) fail_timeout("r_response");
  endtask

  // Called at posedge+1; returns at posedge+1 after both AW and W were accepted.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input bit wait_resp);
    int idx, n, aw_c, w_c;
    bit aw_done, w_done, aw_rdy, w_rdy;
    logic [31:0] nv;
    pulse_t p;
    idx = int'(addr[3:2]);
    nv = byte_merge(model[idx], data, strb);
    model[idx] = nv;
    p.pulse = 4'b0001 << idx; p.idx = idx; p.val = nv;
    pq.push_back(p);
    bq.push_back(2'b00);
    b_issued++;
    aw_done = 0; w_done = 0; n = 0; aw_c = 0; w_c = 0;
    S_AXI_AWADDR = addr; S_AXI_AWPROT = 3'($urandom);
    S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && n < 100) begin
      S_AXI_AWVALID = !aw_done && (n >= aw_dly);
      S_AXI_WVALID  = !w_done && (n >= w_dly);
      @(negedge ACLK);
      aw_rdy = S_AXI_AWREADY;
      w_rdy  = S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (S_AXI_AWVALID && aw_rdy) begin aw_done = 1; aw_c = cyc; end
      if (S_AXI_WVALID && w_rdy)   begin w_done = 1;  w_c = cyc; end
      n++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) fail_timeout("write_accept");
    else if (wait_resp) begin
      wait_b();
      chk("pulse_latency", last_pulse_cyc, ((aw_c > w_c) ? aw_c : w_c) + 1);
    end
  endtask

  task automatic do_read(input logic [3:0] addr);
    int n;
    bit done, rdy;
    rq.push_back(model[int'(addr[3:2])]);
    r_issued++;
    S_AXI_ARADDR = addr; S_AXI_ARPROT = 3'($urandom);
    done = 0; n = 0;
    while (!done && n < 100) begin
      S_AXI_ARVALID = 1'b1;
      @(negedge ACLK); rdy = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      done = rdy;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!done) fail_timeout("read_accept");
    else wait_r();
  endtask

  initial begin
    bit aw_rdy, w_rdy, ar_rdy;
    logic [31:0] old_v, rexp;
    pulse_t p;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 1; S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0;
    S_AXI_RREADY = 1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    ARESET = 1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", {31'd0, S_AXI_AWREADY}, 0);
    chk("rst_wready", {31'd0, S_AXI_WREADY}, 0);
    chk("rst_arready", {31'd0, S_AXI_ARREADY}, 0);
    chk("rst_bvalid", {31'd0, S_AXI_BVALID}, 0);
    chk("rst_rvalid", {31'd0, S_AXI_RVALID}, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_pulse", {28'd0, wr_pulse_o}, 0);
    for (int i = 0; i < 4; i++) chk("rst_reg", get_reg(i), 0);
    @(posedge ACLK); #1;
    ARESET = 0;
    @(negedge ACLK);
    chk("post_rst_awready", {31'd0, S_AXI_AWREADY}, 1);
    chk("post_rst_wready", {31'd0, S_AXI_WREADY}, 1);
    chk("post_rst_arready", {31'd0, S_AXI_ARREADY}, 1);
    @(posedge ACLK); #1;

    for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 1);
    for (int i = 0; i < 4; i++) do_read(4'(i * 4));

    do_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 1);
    chk("w_before_aw_reg2", reg2_o, 32'hDEADBEEF);

    do_write(4'h4, 32'h00000002, 4'hF, 0, 0, 1);
    do_write(4'h4, 32'hAABBCCDD, 4'b0010, 0, 1, 1);
    chk("strobe_merge_reg1", reg1_o, 32'h0000CC02);

    // B back-pressure: a second write is presented but must not be taken.
    S_AXI_BREADY = 0;
    do_write(4'hC, 32'h12345678, 4'hF, 0, 0, 0);
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1; S_AXI_WDATA = 32'h0BADF00D; S_AXI_WVALID = 1;
    @(posedge ACLK); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("stall_bvalid", {31'd0, S_AXI_BVALID}, 1);
      chk("stall_awready", {31'd0, S_AXI_AWREADY}, 0);
      chk("stall_wready", {31'd0, S_AXI_WREADY}, 0);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1; S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    wait_b();
    @(negedge ACLK);
    chk("after_b_bvalid", {31'd0, S_AXI_BVALID}, 0);
    chk("after_b_awready", {31'd0, S_AXI_AWREADY}, 1);
    @(posedge ACLK); #1;
    do_write(4'h0, 32'hCAFEF00D, 4'hF, 0, 0, 1);

    // Read of reg1 sampled on the same edge the write of 0x55 lands.
    old_v = model[1];
    p.pulse = 4'b0010; p.idx = 1; p.val = 32'h55;
    pq.push_back(p); bq.push_back(2'b00); b_issued++;
    rq.push_back(old_v); r_issued++;
    model[1] = 32'h55;
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    @(negedge ACLK); aw_rdy = S_AXI_AWREADY; w_rdy = S_AXI_WREADY;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    chk("coll_aw_w_accept", {30'd0, aw_rdy, w_rdy}, 3);
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1;
    @(negedge ACLK); ar_rdy = S_AXI_ARREADY;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    chk("coll_ar_accept", {31'd0, ar_rdy}, 1);
    wait_b();
    wait_r();
    do_read(4'h4);
    do_read(4'h7);

    // Reset while a read response is stalled and an address is half-latched.
    rexp = model[2];
    S_AXI_RREADY = 0;
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1;
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1;
    @(negedge ACLK); ar_rdy = S_AXI_ARREADY; aw_rdy = S_AXI_AWREADY;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0; S_AXI_AWVALID = 0;
    chk("abort_setup_accept", {30'd0, ar_rdy, aw_rdy}, 3);
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      chk("rstall_rvalid", {31'd0, S_AXI_RVALID}, 1);
      chk("rstall_rdata", S_AXI_RDATA, rexp);
      @(posedge ACLK); #1;
    end
    ARESET = 1;
    @(posedge ACLK); #1;
    ARESET = 0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(negedge ACLK);
    chk("abort_rvalid", {31'd0, S_AXI_RVALID}, 0);
    chk("abort_arready", {31'd0, S_AXI_ARREADY}, 1);
    chk("abort_awready", {31'd0, S_AXI_AWREADY}, 1);
    chk("abort_wready", {31'd0, S_AXI_WREADY}, 1);
    chk("abort_bvalid", {31'd0, S_AXI_BVALID}, 0);
    for (int i = 0; i < 4; i++) chk("abort_reg", get_reg(i), 0);
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1;
    repeat (3) @(posedge ACLK);
    #1;

    bp_en = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0)
        do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1);
      else
        do_read(4'($urandom_range(0, 15)));
    end
    bp_en = 0;
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    for (int i = 0; i < 4; i++) do_read(4'(i * 4));

    repeat (4) @(posedge ACLK);
    chk("pulse_queue_drained", pq.size(), 0);
    chk("b_queue_drained", bq.size(), 0);
    chk("r_queue_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
